// File: rtl/uart_tx_frame.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, 1-2 stop bits.
// Latency: line drops on the accept edge. Only one frame in flight; tx_start is ignored while busy.
module uart_tx_frame #(
    parameter int BAUD_DIV   = 4,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       baud_tick
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BAUD_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [OS_W-1:0]  tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             serial_q, serial_d;

    logic tick;
    logic bit_end;
    logic done;
    logic ready;
    logic accept;

    assign tick    = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign bit_end = tick && (tick_q == OS_LAST);
    assign done    = (state_q == S_STOP) && bit_end && (bit_q == LAST_STOP);
    // The last cycle of the final stop bit also accepts, so frames can abut.
    assign ready   = (state_q == S_IDLE) || done;
    assign accept  = tx_start && ready;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        serial_d = serial_q;

        if (state_q != S_IDLE) begin
            if (tick) begin
                div_d  = '0;
                tick_d = (tick_q == OS_LAST) ? '0 : tick_q + 1'b1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end

        if (bit_end) begin
            case (state_q)
                S_START: begin
                    state_d  = S_DATA;
                    bit_d    = 3'd0;
                    serial_d = shift_q[0];
                end
                S_DATA: begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d  = S_PARITY;
                            serial_d = parity_q;
                        end else begin
                            state_d  = S_STOP;
                            bit_d    = 3'd0;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        serial_d = shift_q[1];
                    end
                end
                S_PARITY: begin
                    state_d  = S_STOP;
                    bit_d    = 3'd0;
                    serial_d = 1'b1;
                end
                S_STOP: begin
                    serial_d = 1'b1;
                    if (bit_q == LAST_STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                end
            endcase
        end

        if (accept) begin
            state_d  = S_START;
            div_d    = '0;
            tick_d   = '0;
            bit_d    = 3'd0;
            shift_d  = tx_data;
            parity_d = (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
            serial_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            tick_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            serial_q <= serial_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_ready  = ready;
    assign tx_busy   = ~ready;
    assign tx_done   = done;
    assign baud_tick = tick;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameterisations checked cycle-by-cycle against a frame-level model,
// plus literal frame/latency expectations and a sampling receiver on instance 0.
module tb_uart_tx_frame;

    localparam int BD = 4;
    localparam int BP = BD * 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] st;
    logic [7:0] dat [3];
    logic [2:0] rdy, ser, busy, done, tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame #(.BAUD_DIV(BD), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(rst), .tx_start(st[0]), .tx_data(dat[0]), .tx_ready(rdy[0]),
        .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]), .baud_tick(tick[0]));
    uart_tx_frame #(.BAUD_DIV(BD), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(rst), .tx_start(st[1]), .tx_data(dat[1]), .tx_ready(rdy[1]),
        .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]), .baud_tick(tick[1]));
    uart_tx_frame #(.BAUD_DIV(BD), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(rst), .tx_start(st[2]), .tx_data(dat[2]), .tx_ready(rdy[2]),
        .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]), .baud_tick(tick[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int pen(input int i);
        return (i != 2) ? 1 : 0;
    endfunction
    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // Line value for each bit period of a frame; unused upper positions stay at the idle level.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input int i);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (pen(i) != 0) f[9] = (i == 1) ? ~^d : ^d;
        return f;
    endfunction

    // Frame-level model: for each instance, the accept edge and bit pattern of the frame in flight.
    bit          minf [3] = '{0, 0, 0};
    int          ma   [3];
    int          mlen [3];
    logic [11:0] mfb  [3];

    always @(negedge clk) begin
        int k;
        logic ed;
        logic [4:0] ev;
        for (int i = 0; i < 3; i++) begin
            ed = 1'b0;
            if (!rst) begin
                minf[i] = 0;
                ev = 5'b11000;
            end else if (minf[i]) begin
                k  = cyc - ma[i];
                ed = (k == mlen[i] * BP - 1);
                ev = {mfb[i][k / BP], ed, !ed, ed, (k % BD) == BD - 1};
            end else begin
                ev = 5'b11000;
            end
            chk($sformatf("frame%0d_cyc%0d {ser,rdy,busy,done,tick}", i, cyc),
                {27'd0, ser[i], rdy[i], busy[i], done[i], tick[i]}, {27'd0, ev});
            if (rst && st[i] && ev[3]) begin
                minf[i] = 1;
                ma[i]   = cyc + 1;
                mfb[i]  = frame_bits(dat[i], i);
                mlen[i] = 9 + pen(i) + nstop(i);
            end else if (ed) begin
                minf[i] = 0;
            end
        end
    end

    // Mid-bit sampling receiver on instance 0 (even parity, 1 stop).
    logic [7:0]  rx_q [$];
    int          rx_frames = 0;
    bit          rx_act = 0;
    int          rx_n = 0;
    logic [10:0] rx_sh;

    always @(negedge clk) begin
        if (!rst) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (ser[0] == 1'b0) begin
                rx_act = 1;
                rx_n   = 0;
            end
        end else begin
            rx_n++;
            if (rx_n % BP == BP / 2) begin
                rx_sh[rx_n / BP] = ser[0];
                if (rx_n / BP == 10) begin
                    rx_act = 0;
                    rx_frames++;
                    if (rx_sh[0] == 1'b0 && rx_sh[10] == 1'b1 && (^rx_sh[9:1]) == 1'b0)
                        rx_q.push_back(rx_sh[8:1]);
                end
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, output int acc);
        @(posedge clk);
        #1;
        st[i]  = 1'b1;
        dat[i] = d;
        acc    = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (rdy[i]) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) chk($sformatf("accept_timeout%0d", i), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        st[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int e);
        e = -1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done[i]) begin
                e = cyc + 1;
                break;
            end
        end
        if (e < 0) chk($sformatf("done_timeout%0d", i), 32'd0, 32'd1);
    endtask

    task automatic capture(input int i, input int nb, output logic [11:0] v);
        v = '1;
        repeat (BP / 2 + 1) @(negedge clk);
        v[0] = ser[i];
        for (int j = 1; j < nb; j++) begin
            repeat (BP) @(negedge clk);
            v[j] = ser[i];
        end
    endtask

    task automatic rand_stream(input int i, input int cnt, inout logic [7:0] sent [$]);
        int a, e;
        logic [7:0] d;
        for (int n = 0; n < cnt; n++) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            d = 8'($urandom);
            if (i == 0) sent.push_back(d);
            send(i, d, a);
            wait_done(i, e);
        end
    endtask

    initial begin
        int a, a2, e, nd;
        logic [11:0] v;
        logic [7:0] s0 [$];
        logic [7:0] s1 [$];
        logic [7:0] s2 [$];

        rst = 1'b0;
        st  = 3'b000;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // Idle after reset
        nd = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done != 3'b000 || tick != 3'b000) nd++;
        end
        chk("idle_done_tick", nd, 0);
        chk("idle_ser", {29'd0, ser}, 32'h7);
        chk("idle_rdy", {29'd0, rdy}, 32'h7);

        // 0xA5, even parity, one stop bit
        rx_q.delete();
        send(0, 8'hA5, a);
        capture(0, 11, v);
        chk("a5_bits", {20'd0, v}, {20'd0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0});
        wait_done(0, e);
        chk("a5_done_latency", e - a, 704);
        chk("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a5_rx_byte", {24'd0, rx_q[0]}, 32'hA5);

        // Odd parity and no-parity/two-stop variants
        send(1, 8'h01, a);
        capture(1, 11, v);
        chk("odd01_bits", {20'd0, v}, {20'd0, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0});
        wait_done(1, e);
        chk("odd01_done_latency", e - a, 704);
        send(2, 8'hFF, a);
        capture(2, 11, v);
        chk("ff_2stop_bits", {20'd0, v}, {20'd0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0});
        wait_done(2, e);
        chk("ff_2stop_done_latency", e - a, 704);

        // Back-to-back with tx_start held high
        rx_q.delete();
        @(posedge clk);
        #1;
        st[0]  = 1'b1;
        dat[0] = 8'h3C;
        a = -1;
        for (int n = 0; n < 100 && a < 0; n++) begin
            @(negedge clk);
            if (rdy[0]) a = cyc + 1;
        end
        @(posedge clk);
        #1;
        dat[0] = 8'hC3;
        a2 = -1;
        for (int n = 0; n < 1000 && a2 < 0; n++) begin
            @(negedge clk);
            if (rdy[0]) a2 = cyc + 1;
        end
        @(posedge clk);
        #1;
        st[0] = 1'b0;
        chk("b2b_accept_spacing", a2 - a, 704);
        wait_done(0, e);
        chk("b2b_second_done", e - a2, 704);
        chk("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("b2b_rx0", {24'd0, rx_q[0]}, 32'h3C);
            chk("b2b_rx1", {24'd0, rx_q[1]}, 32'hC3);
        end

        // Start pulse and data change while busy are ignored
        rx_q.delete();
        send(0, 8'h96, a);
        repeat (150) @(posedge clk);
        #1;
        st[0]  = 1'b1;
        dat[0] = 8'h55;
        @(posedge clk);
        #1;
        st[0]  = 1'b0;
        dat[0] = 8'h00;
        wait_done(0, e);
        chk("busy_ignore_latency", e - a, 704);
        repeat (100) @(negedge clk);
        chk("busy_ignore_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("busy_ignore_rx_byte", {24'd0, rx_q[0]}, 32'h96);
        chk("busy_ignore_idle", {31'd0, rdy[0]}, 32'd1);

        // Reset during data bit 3 aborts the frame
        rx_q.delete();
        send(0, 8'h0F, a);
        repeat (280) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_ser", {31'd0, ser[0]}, 32'd1);
        chk("rst_async_rdy", {31'd0, rdy[0]}, 32'd1);
        chk("rst_async_done", {31'd0, done[0]}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        repeat (800) @(negedge clk);
        chk("rst_no_frame", rx_q.size(), 0);
        send(0, 8'h81, a);
        wait_done(0, e);
        chk("post_rst_latency", e - a, 704);
        repeat (10) @(negedge clk);
        chk("post_rst_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("post_rst_rx_byte", {24'd0, rx_q[0]}, 32'h81);

        // Loopback of fixed bytes
        rx_q.delete();
        nd = rx_frames;
        send(0, 8'h00, a);
        wait_done(0, e);
        send(0, 8'hFF, a);
        wait_done(0, e);
        send(0, 8'h5A, a);
        wait_done(0, e);
        repeat (10) @(negedge clk);
        chk("loop_frames", rx_frames - nd, 3);
        chk("loop_rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            chk("loop_rx0", {24'd0, rx_q[0]}, 32'h00);
            chk("loop_rx1", {24'd0, rx_q[1]}, 32'hFF);
            chk("loop_rx2", {24'd0, rx_q[2]}, 32'h5A);
        end

        // Random traffic on all three instances concurrently
        rx_q.delete();
        fork
            rand_stream(0, 5, s0);
            rand_stream(1, 5, s1);
            rand_stream(2, 5, s2);
        join
        repeat (10) @(negedge clk);
        chk("rand_rx_count", rx_q.size(), s0.size());
        for (int n = 0; n < s0.size() && n < rx_q.size(); n++)
            chk($sformatf("rand_rx%0d", n), {24'd0, rx_q[n]}, {24'd0, s0[n]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
